// File: rtl/design_mux_pkg.sv
// rtl/design_mux_pkg.sv - shared register indices, FSM states and pad constants for the design mux
package design_mux_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd1;
  localparam logic [2:0] REG_COUNT  = 3'd2;
  localparam logic [2:0] REG_CUSTOM = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  localparam int   HOLD_W   = 8;
  localparam logic NONE_OEB = 1'b1;

  typedef enum logic {
    ACTIVE  = 1'b0,
    ISOLATE = 1'b1
  } mux_state_t;

endpackage

// File: rtl/design_mux_wb_regs.sv
// rtl/design_mux_wb_regs.sv - Wishbone pipeline and config/status register file
module design_mux_wb_regs
  import design_mux_pkg::*;
#(
  parameter int SEL_W  = 4,
  parameter int HB_BIT = 25
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cyc,
  input  logic              i_stb,
  input  logic              i_we,
  input  logic              i_blk,
  input  logic [2:0]        i_idx,
  input  logic [31:0]       i_dat,
  output logic [31:0]       o_dat,
  output logic              o_ack,
  input  logic              i_busy,
  input  logic [HOLD_W-1:0] i_hold,
  output logic [SEL_W-1:0]  o_sel,
  output logic              o_override_act,
  output logic              o_rst_override,
  output logic [31:0]       o_custom,
  output logic              o_heartbeat,
  output logic              o_sel_wr_strobe,
  output logic [SEL_W-1:0]  o_new_sel
);

  logic              r_v1, r_blk1, r_we1, r_ack;
  logic [2:0]        r_idx1;
  logic [31:0]       r_dat1, r_dat_o;
  logic [SEL_W-1:0]  r_sel;
  logic              r_ov, r_rov, r_tick;
  logic [31:0]       r_custom, r_cnt;
  logic              w_exec, w_wr, w_rd;
  logic [31:0]       w_rdata;

  assign w_exec = r_v1 & r_blk1;
  assign w_wr   = w_exec & r_we1;
  assign w_rd   = w_exec & ~r_we1;

  always_comb begin
    w_rdata = '1;
    case (r_idx1)
      REG_CTRL:   w_rdata = 32'({r_sel, r_rov, r_ov});
      REG_COUNT:  w_rdata = r_cnt;
      REG_CUSTOM: w_rdata = r_custom;
      REG_STATUS: w_rdata = {16'h0, i_hold, 8'({r_sel, 1'b0, i_busy})};
      default:    w_rdata = '1;
    endcase
  end

  // A held strobe is only captured once: the capture and ack cycles mask it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v1    <= 1'b0;
      r_blk1  <= 1'b0;
      r_we1   <= 1'b0;
      r_idx1  <= '0;
      r_dat1  <= '0;
      r_ack   <= 1'b0;
      r_dat_o <= '0;
    end else begin
      r_v1   <= i_cyc & i_stb & ~r_v1 & ~r_ack;
      r_blk1 <= i_blk;
      r_we1  <= i_we;
      r_idx1 <= i_idx;
      r_dat1 <= i_dat;
      r_ack  <= r_v1;
      if (w_rd) r_dat_o <= w_rdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sel    <= '0;
      r_ov     <= 1'b0;
      r_rov    <= 1'b1;
      r_custom <= '0;
      r_cnt    <= '0;
      r_tick   <= 1'b0;
    end else begin
      if (w_wr && r_idx1 == REG_CTRL) begin
        r_ov  <= r_dat1[0];
        r_rov <= r_dat1[1];
        r_sel <= r_dat1[SEL_W+1:2];
      end
      if (w_wr && r_idx1 == REG_CUSTOM) r_custom <= r_dat1;
      // Loading the counter also restarts the half-rate tick phase.
      if (w_wr && r_idx1 == REG_COUNT) begin
        r_cnt  <= r_dat1;
        r_tick <= 1'b0;
      end else begin
        r_tick <= ~r_tick;
        if (r_tick) r_cnt <= r_cnt + 32'd1;
      end
    end
  end

  assign o_dat           = r_dat_o;
  assign o_ack           = r_ack;
  assign o_sel           = r_sel;
  assign o_override_act  = r_ov;
  assign o_rst_override  = r_rov;
  assign o_custom        = r_custom;
  assign o_heartbeat     = r_cnt[HB_BIT];
  assign o_sel_wr_strobe = w_wr && (r_idx1 == REG_CTRL);
  assign o_new_sel       = r_dat1[SEL_W+1:2];

endmodule

// File: rtl/design_multiplexer_v2.sv
// rtl/design_multiplexer_v2.sv - user design pad multiplexer with break-before-make switchover
module design_multiplexer_v2
  import design_mux_pkg::*;
#(
  parameter int N_DESIGNS = 8,
  parameter int IO_W      = 36,
  parameter int RST_HOLD  = 16,
  parameter int HB_BIT    = 25
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      io_in_0,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_we_i,
  input  logic [31:0]               wbs_adr_i,
  input  logic [31:0]               wbs_dat_i,
  output logic [31:0]               wbs_dat_o,
  output logic                      wbs_ack_o,
  input  logic [N_DESIGNS*IO_W-1:0] io_out_all,
  input  logic [N_DESIGNS*IO_W-1:0] io_oeb_all,
  output logic [N_DESIGNS-1:0]      rst_design,
  output logic [IO_W+1:0]           io_out,
  output logic [IO_W+1:0]           io_oeb,
  output logic [31:0]               custom_settings,
  output logic                      sw_busy
);

  localparam int               SEL_W = $clog2(N_DESIGNS + 1);
  localparam logic [SEL_W-1:0] N_SEL = SEL_W'(N_DESIGNS);

  mux_state_t        r_state, w_state_nxt;
  logic [HOLD_W-1:0] r_hold, w_hold_nxt;
  logic [SEL_W-1:0]  w_sel, w_new_sel, w_pad_sel;
  logic              w_sel_wr_strobe, w_override_act, w_rst_override;
  logic              w_heartbeat, w_base_rst, w_busy;
  logic [IO_W-1:0]   w_slice_out [N_DESIGNS+1];
  logic [IO_W-1:0]   w_slice_oeb [N_DESIGNS+1];
  logic [IO_W-1:0]   w_design_out, w_design_oeb;
  logic              w_unused_adr;

  assign w_unused_adr = ^{wbs_adr_i[31:21], wbs_adr_i[19:5], wbs_adr_i[1:0]};

  design_mux_wb_regs #(
    .SEL_W  (SEL_W),
    .HB_BIT (HB_BIT)
  ) u_regs (
    .i_clk           (wb_clk_i),
    .i_rst           (wb_rst_i),
    .i_cyc           (wbs_cyc_i),
    .i_stb           (wbs_stb_i),
    .i_we            (wbs_we_i),
    .i_blk           (wbs_adr_i[20]),
    .i_idx           (wbs_adr_i[4:2]),
    .i_dat           (wbs_dat_i),
    .o_dat           (wbs_dat_o),
    .o_ack           (wbs_ack_o),
    .i_busy          (w_busy),
    .i_hold          (r_hold),
    .o_sel           (w_sel),
    .o_override_act  (w_override_act),
    .o_rst_override  (w_rst_override),
    .o_custom        (custom_settings),
    .o_heartbeat     (w_heartbeat),
    .o_sel_wr_strobe (w_sel_wr_strobe),
    .o_new_sel       (w_new_sel)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= ACTIVE;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // A selection change restarts isolation from any state, so the last write always wins.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    if (w_sel_wr_strobe && (w_new_sel != w_sel)) begin
      w_state_nxt = ISOLATE;
      w_hold_nxt  = HOLD_W'(RST_HOLD - 1);
    end else if (r_state == ISOLATE) begin
      if (r_hold == '0) w_state_nxt = ACTIVE;
      else              w_hold_nxt  = r_hold - 1'b1;
    end
  end

  assign w_busy     = (r_state == ISOLATE);
  assign sw_busy    = w_busy;
  assign w_base_rst = w_override_act ? w_rst_override : io_in_0;
  assign w_pad_sel  = (w_busy || (w_sel > N_SEL)) ? '0 : w_sel;

  assign w_slice_out[0] = '0;
  assign w_slice_oeb[0] = {IO_W{NONE_OEB}};

  for (genvar d = 1; d <= N_DESIGNS; d++) begin : g_slice
    assign w_slice_out[d]  = io_out_all[(d-1)*IO_W +: IO_W];
    assign w_slice_oeb[d]  = io_oeb_all[(d-1)*IO_W +: IO_W];
    assign rst_design[d-1] = (w_sel == SEL_W'(d)) & (w_base_rst | w_busy);
  end

  assign w_design_out = w_slice_out[w_pad_sel];
  assign w_design_oeb = w_slice_oeb[w_pad_sel];

  assign io_out = {w_design_out[IO_W-1:2], w_heartbeat, w_design_out[1:0], 1'b0};
  assign io_oeb = {w_design_oeb[IO_W-1:2], 1'b0, w_design_oeb[1:0], 1'b1};

endmodule

// File: tb/tb_design_multiplexer_v2.sv
// tb/tb_design_multiplexer_v2.sv - scoreboard bench for the design multiplexer
module tb_design_multiplexer_v2;

  logic         clk, rst, io_in_0, cyc, stb, we;
  logic [31:0]  adr, dat_i, dat_o, custom_settings;
  logic         ack, sw_busy;
  logic [287:0] io_out_all, io_oeb_all;
  logic [7:0]   rst_design;
  logic [37:0]  io_out, io_oeb;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        chk;
    logic [31:0] lo;
    logic [31:0] hi;
    string       name;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  localparam logic [37:0] HB_MASK = ~(38'd1 << 3);

  design_multiplexer_v2 dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .io_in_0(io_in_0),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_dat_o(dat_o), .wbs_ack_o(ack),
    .io_out_all(io_out_all), .io_oeb_all(io_oeb_all), .rst_design(rst_design),
    .io_out(io_out), .io_oeb(io_oeb), .custom_settings(custom_settings), .sw_busy(sw_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endfunction

  function automatic logic [35:0] pat_out(int d);
    logic [7:0] b;
    b = 8'(d);
    return {b[3:0], 16'hC0DE, b, 8'hA0 ^ b};
  endfunction

  function automatic logic [35:0] pat_oeb(int d);
    logic [7:0] b;
    b = 8'(d);
    return {~b[3:0], 16'h0F0F, b << 1, 8'h5A ^ b};
  endfunction

  function automatic logic [37:0] exp_io_out(int s);
    logic [35:0] v;
    v = (s >= 1 && s <= 8) ? pat_out(s) : 36'h0;
    return {v[35:2], 1'b0, v[1:0], 1'b0};
  endfunction

  function automatic logic [37:0] exp_io_oeb(int s);
    logic [35:0] v;
    v = (s >= 1 && s <= 8) ? pat_oeb(s) : {36{1'b1}};
    return {v[35:2], 1'b0, v[1:0], 1'b1};
  endfunction

  function automatic void check_pads(string name, int s);
    chk({name, "_out"}, 64'(io_out & HB_MASK), 64'(exp_io_out(s) & HB_MASK));
    chk({name, "_oeb"}, 64'(io_oeb), 64'(exp_io_oeb(s)));
  endfunction

  // Monitor: every ack consumes one scoreboard entry.
  always @(negedge clk) begin
    if (!rst && ack) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.chk) begin
          checks++;
          if (dat_o < mon_e.lo || dat_o > mon_e.hi) begin
            failures++;
            $display("FAIL %s: dat_o=%h expected %h..%h", mon_e.name, dat_o, mon_e.lo, mon_e.hi);
          end
        end
      end
    end
  end

  // Called just after a rising edge; returns just after a rising edge with the bus idle.
  task automatic wb_xfer(input logic w, input logic blk, input logic [2:0] idx, input logic [31:0] d);
    int lat;
    adr = 32'h0;
    adr[20] = blk;
    adr[4:2] = idx;
    dat_i = d;
    we = w;
    cyc = 1'b1;
    stb = 1'b1;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      if (ack) break;
      lat++;
    end
    chk("ack_latency", 64'(lat), 64'd2);
    @(posedge clk); #1;
    cyc = 1'b0;
    stb = 1'b0;
    we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] idx, input logic [31:0] lo, input logic [31:0] hi, input string name);
    sb.push_back('{1'b1, lo, hi, name});
    wb_xfer(1'b0, 1'b1, idx, 32'h0);
  endtask

  task automatic wr(input logic blk, input logic [2:0] idx, input logic [31:0] d);
    sb.push_back('{1'b0, 32'h0, 32'h0, "write"});
    wb_xfer(1'b1, blk, idx, d);
  endtask

  task automatic watch_iso(input string name, input logic [7:0] exp_rst, input int exp_n, input int final_sel);
    int n;
    logic ok;
    n = 0;
    ok = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!sw_busy) break;
      n++;
      if (rst_design !== exp_rst || (io_out & HB_MASK) !== (exp_io_out(0) & HB_MASK) ||
          io_oeb !== exp_io_oeb(0)) ok = 1'b0;
    end
    chk({name, "_busy_cycles"}, 64'(n), 64'(exp_n));
    chk({name, "_isolated"}, 64'(ok), 64'd1);
    chk({name, "_rst_after"}, 64'(rst_design), 64'h0);
    check_pads({name, "_pads_after"}, final_sel);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; io_in_0 = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = 32'h0; dat_i = 32'h0;
    for (int d = 1; d <= 8; d++) begin
      io_out_all[(d-1)*36 +: 36] = pat_out(d);
      io_oeb_all[(d-1)*36 +: 36] = pat_oeb(d);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("reset_busy", 64'(sw_busy), 64'd0);
    chk("reset_rst_design", 64'(rst_design), 64'h0);
    chk("reset_custom", 64'(custom_settings), 64'h0);
    check_pads("reset_pads", 0);
    @(posedge clk); #1;

    // Test 1: CTRL reset value
    rd(3'd1, 32'h2, 32'h2, "t1_ctrl_reset");

    // Test 2: sel=3 with software reset override released
    wr(1'b1, 3'd1, 32'h0D);
    watch_iso("t2", 8'b0000_0100, 15, 3);

    // Test 3: sel=6, retarget to 5 mid-isolation, then a same-sel rewrite
    wr(1'b1, 3'd1, 32'h19);
    wr(1'b1, 3'd1, 32'h15);
    wr(1'b1, 3'd1, 32'h15);
    watch_iso("t3", 8'b0001_0000, 12, 5);

    // Reset gating source: override value, then external pin
    wr(1'b1, 3'd1, 32'h17);
    chk("t3_same_sel_busy", 64'(sw_busy), 64'd0);
    chk("t3_rst_override", 64'(rst_design), 64'h10);
    wr(1'b1, 3'd1, 32'h14);
    chk("t3_pin_low", 64'(rst_design), 64'h0);
    io_in_0 = 1'b1;
    #1 chk("t3_pin_high", 64'(rst_design), 64'h10);
    io_in_0 = 1'b0;

    // Test 4: out-of-range select behaves as none
    wr(1'b1, 3'd1, 32'h25);
    watch_iso("t4", 8'h00, 15, 0);
    rd(3'd4, 32'h24, 32'h24, "t4_status");
    rd(3'd1, 32'h25, 32'h25, "t4_ctrl");

    // Custom word, read-only and unmapped registers
    wr(1'b1, 3'd3, 32'hDEADBEEF);
    chk("custom_out", 64'(custom_settings), 64'hDEADBEEF);
    rd(3'd3, 32'hDEADBEEF, 32'hDEADBEEF, "custom_rd");
    wr(1'b1, 3'd4, 32'h0);
    rd(3'd4, 32'h24, 32'h24, "status_ro");
    wr(1'b1, 3'd7, 32'h0);
    rd(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, "reg0_rd");

    // Test 5: counter wrap and heartbeat
    wr(1'b1, 3'd2, 32'hFFFFFFFE);
    chk("t5_hb_high", 64'(io_out[3]), 64'd1);
    rd(3'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, "t5_count_rd1");
    rd(3'd2, 32'h0, 32'h1, "t5_count_rd2");
    @(negedge clk);
    chk("t5_hb_low", 64'(io_out[3]), 64'd0);
    @(posedge clk); #1;

    // Test 6: reset mid-switchover
    wr(1'b1, 3'd1, 32'h09);
    chk("t6_busy_before", 64'(sw_busy), 64'd1);
    chk("t6_rst_during", 64'(rst_design), 64'h02);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_busy_after", 64'(sw_busy), 64'd0);
    chk("t6_rst_design_after", 64'(rst_design), 64'h0);
    check_pads("t6_pads", 0);
    @(posedge clk); #1;
    rd(3'd1, 32'h2, 32'h2, "t6_ctrl");
    rd(3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, "t6_reg7");

    // Block select low: acked, no effect
    wr(1'b0, 3'd1, 32'h0D);
    chk("blk0_busy", 64'(sw_busy), 64'd0);
    rd(3'd1, 32'h2, 32'h2, "blk0_ctrl");

    repeat (4) @(posedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
